// File: rtl/intt_coeff_streamer.sv
// rtl/intt_coeff_streamer.sv - INTT coefficient read-out with final mod-q reduction and valid/ready streaming
// Optional feature macro: INTT_STREAM_CENTER_EN (centered two's-complement output when defined)
module intt_coeff_streamer #(
   parameter int N      = 256,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 24,
   parameter int Q      = 8380417
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_A,
   input  logic [DATA_W-1:0] mem_Q,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_index,
   output logic              out_last
);
   localparam logic [DATA_W:0]   Q_X    = (DATA_W+1)'(Q);
   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(N - 1);
`ifdef INTT_STREAM_CENTER_EN
   localparam logic [DATA_W-1:0] Q_W    = DATA_W'(Q);
   localparam logic [DATA_W-1:0] HALF_W = DATA_W'((Q - 1) / 2);
`endif

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic                inflight_q, inflight_d;
   logic [ADDR_W-1:0]   infl_addr_q, infl_addr_d;
   logic [ADDR_W-1:0]   fifo_idx_q  [2];
   logic [DATA_W-1:0]   fifo_data_q [2];
   logic                wr_ptr_q, wr_ptr_d;
   logic                rd_ptr_q, rd_ptr_d;
   logic [1:0]          count_q, count_d;

   logic                pop, push, credit_ok, issue, last_pop;
   logic [DATA_W:0]     diff;
   logic [DATA_W-1:0]   red, wr_data;

   // A read may only be issued if its returning word is guaranteed a FIFO slot
   assign pop       = out_valid & out_ready;
   assign push      = inflight_q;
   assign credit_ok = ({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
   assign issue     = (state_q == S_RUN) && credit_ok;
   assign last_pop  = pop && (out_index == LAST_A);

   // Borrow out of the subtraction means mem_Q < Q
   assign diff = {1'b0, mem_Q} - Q_X;
   assign red  = diff[DATA_W] ? mem_Q : diff[DATA_W-1:0];
`ifdef INTT_STREAM_CENTER_EN
   assign wr_data = (red > HALF_W) ? (red - Q_W) : red;
`else
   assign wr_data = red;
`endif

   assign out_valid = (count_q != 2'd0);
   assign out_data  = fifo_data_q[rd_ptr_q];
   assign out_index = fifo_idx_q[rd_ptr_q];
   assign out_last  = out_valid && (out_index == LAST_A);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (issue && (rd_addr_q == LAST_A)) state_d = S_DRAIN;
         S_DRAIN: if (last_pop) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      mem_rd_en = issue;
      mem_A     = issue ? rd_addr_q : '0;
   end

   always_comb begin
      rd_addr_d = rd_addr_q;
      if ((state_q == S_IDLE) && start) begin
         rd_addr_d = '0;
      end else if (issue) begin
         rd_addr_d = rd_addr_q + ADDR_W'(1);
      end
      inflight_d  = issue;
      infl_addr_d = issue ? rd_addr_q : infl_addr_q;
      wr_ptr_d    = wr_ptr_q ^ push;
      rd_ptr_d    = rd_ptr_q ^ pop;
      count_d     = count_q + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_addr_q   <= '0;
         inflight_q  <= 1'b0;
         infl_addr_q <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            fifo_idx_q[i]  <= '0;
            fifo_data_q[i] <= '0;
         end
      end else begin
         rd_addr_q   <= rd_addr_d;
         inflight_q  <= inflight_d;
         infl_addr_q <= infl_addr_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         if (push) begin
            fifo_idx_q[wr_ptr_q]  <= infl_addr_q;
            fifo_data_q[wr_ptr_q] <= wr_data;
         end
      end
   end

endmodule

// File: tb/tb_intt_coeff_streamer.sv
// tb/tb_intt_coeff_streamer.sv - self-checking bench for intt_coeff_streamer
// Honours INTT_STREAM_CENTER_EN for expected output values.
module tb_intt_coeff_streamer;
   localparam int QM = 8380417;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        busy, done, mem_rd_en;
   logic [7:0]  mem_A;
   logic [23:0] mem_Q = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [23:0] out_data;
   logic [7:0]  out_index;
   logic        out_last;

   int checks = 0;
   int errors = 0;

   logic [23:0] mem [0:255];

   logic [23:0] got_data [$];
   int          got_idx  [$];
   logic        got_last [$];
   int          got_cyc  [$];
   int          done_cyc [$];
   int          first_rd_cyc, first_rd_addr, busy_low_cyc, busy_c0;
   int          stall_viol, credit_viol, post_rst;
   logic        rst_valid, rst_busy, timed_out;

   intt_coeff_streamer dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .mem_rd_en(mem_rd_en), .mem_A(mem_A), .mem_Q(mem_Q),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_index(out_index), .out_last(out_last)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd_en) mem_Q <= mem[mem_A];
   end

   function automatic logic [23:0] model(input logic [23:0] v);
      int r;
      r = int'(v) % QM;
`ifdef INTT_STREAM_CENTER_EN
      if (r > (QM - 1) / 2) r = r - QM;
`endif
      return r[23:0];
   endfunction

   task automatic run_stream(input int ready_pct, input int restart_at, input int rst_beat);
      int cyc, issued, popped, pcnt;
      logic p, hold, stop, pl;
      logic [23:0] pd;
      logic [7:0] pi;
      got_data.delete(); got_idx.delete(); got_last.delete(); got_cyc.delete(); done_cyc.delete();
      first_rd_cyc = -1; first_rd_addr = -1; busy_low_cyc = -1; busy_c0 = -1;
      stall_viol = 0; credit_viol = 0; post_rst = -1; timed_out = 1'b0;
      rst_valid = 1'b1; rst_busy = 1'b1;
      @(posedge clk); #1;
      start = 1'b1;
      out_ready = ($urandom_range(99) < ready_pct);
      cyc = 0; issued = 0; popped = 0; hold = 0; stop = 0;
      pd = '0; pi = '0; pl = 0;
      while (!stop) begin
         @(negedge clk);
         if (cyc == 0) busy_c0 = busy;
         if (hold && !(out_valid && out_data == pd && out_index == pi && out_last == pl)) stall_viol++;
         p = out_valid && out_ready;
         pcnt = p ? 1 : 0;
         if (mem_rd_en && (issued - popped - pcnt) >= 2) credit_viol++;
         if (mem_rd_en && first_rd_cyc < 0) begin
            first_rd_cyc = cyc;
            first_rd_addr = mem_A;
         end
         if (mem_rd_en) issued++;
         if (p) begin
            got_data.push_back(out_data);
            got_idx.push_back(int'(out_index));
            got_last.push_back(out_last);
            got_cyc.push_back(cyc);
            popped++;
         end
         if (done) done_cyc.push_back(cyc);
         if (post_rst < 0 && cyc > 0 && !busy && busy_low_cyc < 0) busy_low_cyc = cyc;
         hold = out_valid && !out_ready;
         pd = out_data; pi = out_index; pl = out_last;
         if (post_rst < 0 && busy_low_cyc >= 0) stop = 1;
         if (post_rst >= 0 && cyc >= post_rst + 12) stop = 1;
         if (cyc >= 3000) begin
            stop = 1;
            timed_out = 1'b1;
         end
         @(posedge clk); #1;
         cyc++;
         start = 1'b0;
         rst = 1'b0;
         out_ready = ($urandom_range(99) < ready_pct);
         if (restart_at >= 0 && p && int'(pi) == restart_at) start = 1'b1;
         if (rst_beat >= 0 && post_rst < 0 && popped == rst_beat) begin
            rst = 1'b1;
            #1;
            rst_valid = out_valid;
            rst_busy = busy;
            post_rst = cyc;
            hold = 0;
            issued = 0;
            popped = 0;
         end
      end
      rst = 1'b0;
      start = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", mem_rd_en); end
      checks++; if (mem_A !== 8'd0) begin errors++; $display("FAIL reset_mem_A got %0d want 0", mem_A); end
      checks++; if (out_data !== 24'd0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
      checks++; if (out_index !== 8'd0) begin errors++; $display("FAIL reset_out_index got %0d want 0", out_index); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if ({busy, out_valid, mem_rd_en, done} !== 4'b0) begin errors++; $display("FAIL idle_after_reset got %b want 0000", {busy, out_valid, mem_rd_en, done}); end
   endtask

   task automatic check_stream(input string name);
      checks++;
      if (timed_out) begin errors++; $display("FAIL %s_timeout got cycle budget exhausted want completion", name); end
      checks++;
      if (got_idx.size() != 256) begin errors++; $display("FAIL %s_beat_count got %0d want 256", name, got_idx.size()); end
      for (int i = 0; i < got_idx.size() && i < 256; i++) begin
         checks++;
         if (got_idx[i] != i || got_data[i] !== model(mem[i]) || got_last[i] !== (i == 255)) begin
            errors++;
            $display("FAIL %s_beat%0d got idx=%0d data=%h last=%b want idx=%0d data=%h last=%b",
                     name, i, got_idx[i], got_data[i], got_last[i], i, model(mem[i]), (i == 255));
         end
      end
      checks++;
      if (done_cyc.size() != 1) begin errors++; $display("FAIL %s_done_count got %0d want 1", name, done_cyc.size()); end
      checks++;
      if (stall_viol != 0) begin errors++; $display("FAIL %s_head_stable got %0d violations want 0", name, stall_viol); end
      checks++;
      if (credit_viol != 0) begin errors++; $display("FAIL %s_credit got %0d violations want 0", name, credit_viol); end
   endtask

   task automatic test_latency;
      for (int i = 0; i < 256; i++) mem[i] = 24'(i);
      run_stream(100, -1, -1);
      check_stream("latency");
      checks++; if (busy_c0 != 0) begin errors++; $display("FAIL lat_busy_c0 got %0d want 0", busy_c0); end
      checks++; if (first_rd_cyc != 1 || first_rd_addr != 0) begin errors++; $display("FAIL lat_first_read got cyc=%0d addr=%0d want cyc=1 addr=0", first_rd_cyc, first_rd_addr); end
      checks++; if (got_cyc.size() < 256 || got_cyc[0] != 3 || got_cyc[255] != 258) begin errors++; $display("FAIL lat_beat_cycles got first=%0d last=%0d want 3 258", got_cyc.size() ? got_cyc[0] : -1, got_cyc.size() == 256 ? got_cyc[255] : -1); end
      checks++; if (done_cyc.size() != 1 || done_cyc[0] != 259) begin errors++; $display("FAIL lat_done_cycle got %0d want 259", done_cyc.size() ? done_cyc[0] : -1); end
      checks++; if (busy_low_cyc != 260) begin errors++; $display("FAIL lat_busy_low got %0d want 260", busy_low_cyc); end
   endtask

   task automatic test_reduction;
      logic [23:0] w0, w1, w2, w3, w4;
      for (int i = 0; i < 256; i++) mem[i] = 24'($urandom_range(2 * QM - 1));
      mem[0] = 24'd8380417; mem[1] = 24'd8380418; mem[2] = 24'd16760833;
      mem[3] = 24'd4190208; mem[4] = 24'd4190209;
`ifdef INTT_STREAM_CENTER_EN
      w0 = 24'd0; w1 = 24'd1; w2 = 24'hFFFFFF; w3 = 24'h3FF000; w4 = 24'hC01000;
`else
      w0 = 24'd0; w1 = 24'd1; w2 = 24'd8380416; w3 = 24'h3FF000; w4 = 24'h3FF001;
`endif
      run_stream(100, -1, -1);
      check_stream("reduce");
      checks++;
      if (got_data.size() < 5 || got_data[0] !== w0 || got_data[1] !== w1 || got_data[2] !== w2 || got_data[3] !== w3 || got_data[4] !== w4) begin
         errors++;
         $display("FAIL reduce_boundary got %h %h %h %h %h want %h %h %h %h %h",
                  got_data.size() > 0 ? got_data[0] : 24'hx, got_data.size() > 1 ? got_data[1] : 24'hx,
                  got_data.size() > 2 ? got_data[2] : 24'hx, got_data.size() > 3 ? got_data[3] : 24'hx,
                  got_data.size() > 4 ? got_data[4] : 24'hx, w0, w1, w2, w3, w4);
      end
   endtask

   task automatic test_backpressure;
      for (int i = 0; i < 256; i++) mem[i] = 24'(i);
      run_stream(50, -1, -1);
      check_stream("bp50");
      for (int i = 0; i < 256; i++) mem[i] = 24'($urandom_range(2 * QM - 1));
      run_stream(25, -1, -1);
      check_stream("bp25_rand");
   endtask

   task automatic test_start_while_busy;
      for (int i = 0; i < 256; i++) mem[i] = 24'($urandom_range(2 * QM - 1));
      run_stream(100, 100, -1);
      check_stream("restart_ignored");
   endtask

   task automatic test_reset_mid_stream;
      for (int i = 0; i < 256; i++) mem[i] = 24'(i);
      run_stream(100, -1, 50);
      checks++; if (rst_valid !== 1'b0 || rst_busy !== 1'b0) begin errors++; $display("FAIL midrst_async got valid=%b busy=%b want 0 0", rst_valid, rst_busy); end
      checks++; if (done_cyc.size() != 0) begin errors++; $display("FAIL midrst_no_done got %0d pulses want 0", done_cyc.size()); end
      checks++; if (got_idx.size() != 50) begin errors++; $display("FAIL midrst_beats got %0d want 50", got_idx.size()); end
      for (int i = 0; i < 256; i++) mem[i] = 24'($urandom_range(2 * QM - 1));
      run_stream(70, -1, -1);
      check_stream("after_midrst");
   endtask

   initial begin
      test_reset();
      test_latency();
      test_reduction();
      test_backpressure();
      test_start_while_busy();
      test_reset_mid_stream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/intt_coeff_streamer.md
Name: intt_coeff_streamer

Overview:
- Downstream neighbour of the INTT core.
- After the INTT signals completion, it reads the 256 coefficients out of the INTT coefficient memory through a synchronous read port with 1-cycle latency.
- Each coefficient gets a final conditional subtraction modulo q = 8380417.
- Results stream to the next stage over a valid/ready interface with full backpressure support.

Parameters:
- N, 256, number of coefficients per polynomial
- ADDR_W, 8, memory address width (log2 N)
- DATA_W, 24, coefficient width
- Q, 8380417, Dilithium modulus

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse, driven from INTT done_NTT
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final beat is transferred
- mem_rd_en  out  1  read strobe to the INTT memory
- mem_A  out  ADDR_W  read address
- mem_Q  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_data  out  DATA_W  reduced coefficient
- out_index  out  ADDR_W  coefficient index of the current beat
- out_last  out  1  high on the beat with index N-1

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, counters 0. Reset acts immediately and asynchronously.
- FSM states:
  - IDLE -> RUN when start=1.
  - RUN -> DRAIN when read address N-1 has been issued.
  - DRAIN -> DONE when the beat with index N-1 is handshaken.
  - DONE -> IDLE unconditionally; done=1 for this single cycle.
- start is ignored in RUN, DRAIN and DONE.
- Read issue: in RUN, mem_rd_en=1 with mem_A=rd_addr only when (fifo_count + inflight - pop) < 2, where pop = out_valid & out_ready. rd_addr increments by 1 per issued read. inflight is 1 in the cycle after an issue.
- Output buffer: a 2-entry FIFO of {index, reduced data}. Returning mem_Q is always written into it; the credit rule guarantees it never overflows.
- Reduction, applied to mem_Q as it is written: r = (mem_Q >= Q) ? mem_Q - Q : mem_Q, computed in DATA_W+1 bits. Input is guaranteed < 2Q.
- Output: out_valid = FIFO not empty; out_data, out_index and out_last come from the FIFO head.
  - The head must hold stable while out_valid=1 and out_ready=0.
  - Beats are strictly in index order 0..N-1 with no gaps or duplicates.
- Latency with out_ready held high:
  - start sampled at edge 0.
  - mem_rd_en=1 (A=0) in cycle 1.
  - out_valid=1 (index 0) in cycle 3.
  - One beat per cycle; index 255 in cycle 258.
  - done pulse in cycle 259; busy is low in cycle 260.
- Backpressure: out_ready=0 for any duration stalls reads after at most 2 buffered entries; no data is lost.
- Simultaneous push and pop on a full FIFO is legal (count stays 2).
- rst asserted mid-operation: FIFO is flushed, no done pulse is produced, and the FSM returns to IDLE. A later start restarts from index 0.

Optional Feature:
- Macro: INTT_STREAM_CENTER_EN.
  - Defined: after reduction, any r > (Q-1)/2 = 4190208 is output as r - Q in DATA_W-bit two's complement (centered representation for the downstream decompose/hint logic).
  - Undefined: out_data is r in [0, Q-1].
- Timing and handshakes are identical in both builds.

Test Plan:
- mem[i]=i, out_ready=1, pulse start -> 256 beats with out_data=out_index=i on cycles 3..258; out_last only at i=255; done pulse at cycle 259.
- mem[0]=8380417, mem[1]=8380418, mem[2]=16760833 -> out_data 0, 1, 8380416 (center build: 0, 1, 24'hFFFFFF).
- Center build: mem[0]=4190208, mem[1]=4190209 -> 24'h3FF000, 24'hC01000. Non-center build: 24'h3FF000, 24'h3FF001.
- Random out_ready (50% duty) with mem[i]=i -> all 256 values in order, none dropped or duplicated; the FIFO head holds stable while stalled; mem_rd_en never fires while 2 entries are pending.
- Pulse start again while busy (at index 100) -> ignored, stream continues to 255 with a single done pulse.
- Assert rst at beat 50 for 1 cycle -> out_valid=0 and busy=0 immediately, no done pulse; a new start streams again from index 0.
